// File: rtl/int_to_float_seq_pkg.sv
// ---------------------------------------------------------------------------
// int_to_float_seq_pkg
// Shared definitions for the sequential integer-to-float converter and for
// any future float blocks that reuse the rounding stage.
//   FP_BIAS / FP_EXP_W / FP_FRAC_W : IEEE-754 single-precision field constants
//   POS_W                          : width of the bit-position counter, wide
//                                    enough for positions 0..63
//   state_t                        : converter FSM states
// ---------------------------------------------------------------------------
package int_to_float_seq_pkg;

  localparam int FP_BIAS   = 127;
  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;
  localparam int POS_W     = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fp_round_rne.sv
// ---------------------------------------------------------------------------
// fp_round_rne
// Combinational packer/rounder. Takes an already-normalised magnitude (its
// leading one removed), the position of that leading one and the sign, and
// builds the IEEE-754 single-precision word.
// Parameters:
//   IN_WIDTH   : width of the normalised magnitude (leading one included)
//   ROUND_MODE : 0 = round-to-nearest-even, 1 = truncate toward zero
// Ports:
//   i_sign      : sign bit of the result
//   i_frac_bits : magnitude bits below the leading one, MSB-aligned
//   i_pos       : bit position of the leading one (unbiased exponent)
//   o_word      : {sign, exp[7:0], frac[22:0]}
// ---------------------------------------------------------------------------
module fp_round_rne
  import int_to_float_seq_pkg::*;
#(
  parameter int IN_WIDTH   = 16,
  parameter int ROUND_MODE = 0
) (
  input  logic                i_sign,
  input  logic [IN_WIDTH-2:0] i_frac_bits,
  input  logic [POS_W-1:0]    i_pos,
  output logic [31:0]         o_word
);

  logic [IN_WIDTH+23:0]  w_ext;
  logic [FP_FRAC_W-1:0]  w_frac;
  logic                  w_guard;
  logic                  w_sticky;
  logic                  w_inc;
  logic [FP_FRAC_W:0]    w_frac_sum;
  logic [FP_EXP_W-1:0]   w_exp;

  // Padding the fraction bits with 25 zeros makes one slicing scheme work for
  // every width: narrow inputs get a zero-padded fraction with guard and
  // sticky falling into the padding (so they are always 0), while wide inputs
  // push real bits into guard and sticky.
  assign w_ext    = {i_frac_bits, 25'd0};
  assign w_frac   = w_ext[IN_WIDTH+23 -: FP_FRAC_W];
  assign w_guard  = w_ext[IN_WIDTH];
  assign w_sticky = |w_ext[IN_WIDTH-1:0];

  // Round up past the halfway point, or exactly at halfway when that makes
  // the fraction even.
  assign w_inc = (ROUND_MODE == 0) && w_guard && (w_sticky || w_frac[0]);

  // A carry out of the fraction leaves it all-zero and bumps the exponent;
  // the largest possible exponent (127 + 64) is far below the inf encoding.
  assign w_frac_sum = {1'b0, w_frac} + {{FP_FRAC_W{1'b0}}, w_inc};
  assign w_exp      = FP_EXP_W'(FP_BIAS) + {1'b0, i_pos}
                    + {{(FP_EXP_W-1){1'b0}}, w_frac_sum[FP_FRAC_W]};

  assign o_word = {i_sign, w_exp, w_frac_sum[FP_FRAC_W-1:0]};

endmodule

// File: rtl/int_to_float_seq.sv
// ---------------------------------------------------------------------------
// int_to_float_seq
// Sequential integer to IEEE-754 single-precision converter. An integer is
// accepted through a valid/ready handshake, normalised one bit per clock,
// rounded, and the 32-bit result is held until the consumer takes it.
// Parameters:
//   IN_WIDTH   : input integer width, 2..64
//   SIGNED     : 1 = two's complement input, 0 = unsigned
//   ROUND_MODE : 0 = round-to-nearest-even, 1 = truncate (only matters > 24b)
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : in_a is valid
//   in_ready  : converter is idle and can accept in_a
//   in_a      : integer to convert
//   out_valid : out_b holds a finished result
//   out_ready : consumer accepts out_b
//   out_b     : IEEE-754 single {sign, exp, frac}
// ---------------------------------------------------------------------------
module int_to_float_seq
  import int_to_float_seq_pkg::*;
#(
  parameter int IN_WIDTH   = 16,
  parameter int SIGNED     = 1,
  parameter int ROUND_MODE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_WIDTH-1:0] in_a,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_b
);

  state_t              r_state;
  state_t              w_next_state;
  logic                r_sign;
  logic [IN_WIDTH-1:0] r_mag;
  logic [POS_W-1:0]    r_pos;
  logic [31:0]         r_out_b;

  logic                w_in_neg;
  logic [IN_WIDTH-1:0] w_in_mag;
  logic [31:0]         w_word;

  // Two's complement negation of the most negative value wraps back to
  // 2^(IN_WIDTH-1), which is exactly the magnitude wanted.
  assign w_in_neg = (SIGNED != 0) && in_a[IN_WIDTH-1];
  assign w_in_mag = w_in_neg ? (-in_a) : in_a;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. An input that is already normalised skips NORM, and
  // NORM leaves on the same edge as the shift that brings the leading one to
  // the MSB, so a nonzero result appears lz + 2 edges after acceptance.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          if (w_in_mag == '0) begin
            w_next_state = ST_DONE;
          end else if (w_in_mag[IN_WIDTH-1]) begin
            w_next_state = ST_ROUND;
          end else begin
            w_next_state = ST_NORM;
          end
        end
      end
      ST_NORM: begin
        if (r_mag[IN_WIDTH-1] || r_mag[IN_WIDTH-2]) begin
          w_next_state = ST_ROUND;
        end
      end
      ST_ROUND: begin
        w_next_state = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs follow the state directly, so an asynchronous reset
  // drops out_valid and raises in_ready immediately.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_IDLE: in_ready  = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Datapath: capture on accept, shift toward the MSB while normalising, and
  // register the packed word. out_b is only written on accept of a zero or
  // in ROUND, so it stays put through DONE and after the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign  <= 1'b0;
      r_mag   <= '0;
      r_pos   <= '0;
      r_out_b <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sign <= w_in_neg;
            r_mag  <= w_in_mag;
            r_pos  <= POS_W'(IN_WIDTH-1);
            if (w_in_mag == '0) begin
              r_out_b <= '0;
            end
          end
        end
        ST_NORM: begin
          if (!r_mag[IN_WIDTH-1]) begin
            r_mag <= r_mag << 1;
            r_pos <= r_pos - POS_W'(1);
          end
        end
        ST_ROUND: begin
          r_out_b <= w_word;
        end
        default: begin
          r_out_b <= r_out_b;
        end
      endcase
    end
  end

  fp_round_rne #(
    .IN_WIDTH   (IN_WIDTH),
    .ROUND_MODE (ROUND_MODE)
  ) u_round (
    .i_sign      (r_sign),
    .i_frac_bits (r_mag[IN_WIDTH-2:0]),
    .i_pos       (r_pos),
    .o_word      (w_word)
  );

  assign out_b = r_out_b;

endmodule

// File: tb/tb_int_to_float_seq.sv
// ---------------------------------------------------------------------------
// tb_int_to_float_seq
// Exercises three converter configurations side by side:
//   dut 0 : IN_WIDTH=16, signed,   round-to-nearest-even
//   dut 1 : IN_WIDTH=32, unsigned, round-to-nearest-even
//   dut 2 : IN_WIDTH=32, unsigned, truncate
// ---------------------------------------------------------------------------
module tb_int_to_float_seq;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [2:0]        inValid;
  logic [2:0]        inReady;
  logic [2:0]        outValid;
  logic [2:0]        outReady;
  logic [15:0]       inA16;
  logic [31:0]       inA32;
  logic [2:0][31:0]  outB;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    int          dut;
    logic [31:0] value;
    logic [31:0] expB;
    int          expEdges;
  } vec_t;

  vec_t vectors [10];

  always #5 clk = ~clk;

  int_to_float_seq #(.IN_WIDTH(16), .SIGNED(1), .ROUND_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[0]), .in_ready(inReady[0]),
    .in_a(inA16), .out_valid(outValid[0]), .out_ready(outReady[0]), .out_b(outB[0])
  );

  int_to_float_seq #(.IN_WIDTH(32), .SIGNED(0), .ROUND_MODE(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[1]), .in_ready(inReady[1]),
    .in_a(inA32), .out_valid(outValid[1]), .out_ready(outReady[1]), .out_b(outB[1])
  );

  int_to_float_seq #(.IN_WIDTH(32), .SIGNED(0), .ROUND_MODE(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[2]), .in_ready(inReady[2]),
    .in_a(inA32), .out_valid(outValid[2]), .out_ready(outReady[2]), .out_b(outB[2])
  );

  // Global time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it, reports a failing one.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference magnitude of a width-bit integer as an unbounded number.
  function automatic longint unsigned refMagnitude(input logic [31:0] value,
                                                   input int width, input bit signedIn);
    longint unsigned v;
    v = longint'(value);
    if (signedIn && value[width-1]) begin
      return (64'd1 << width) - v;
    end
    return v;
  endfunction

  // Index of the highest set bit of a nonzero number.
  function automatic int refTopBit(input longint unsigned mag);
    int p;
    p = 0;
    for (int i = 0; i < 64; i++) begin
      if ((mag >> i) != 0) p = i;
    end
    return p;
  endfunction

  // Float value computed arithmetically: scale the magnitude to a 24-bit
  // significand, round the discarded remainder, renormalise on carry.
  function automatic logic [31:0] refConvert(input logic [31:0] value, input int width,
                                             input bit signedIn, input bit truncate);
    longint unsigned mag, q, rem, half;
    int p, e, shift;
    bit neg;
    neg = signedIn && value[width-1];
    mag = refMagnitude(value, width, signedIn);
    if (mag == 0) return 32'h0;
    p = refTopBit(mag);
    e = 127 + p;
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      shift = p - 23;
      q     = mag >> shift;
      rem   = mag - (q << shift);
      half  = 64'd1 << (shift - 1);
      if (!truncate && ((rem > half) || ((rem == half) && (q % 2 == 1)))) q = q + 1;
      if (q == (64'd1 << 24)) begin
        q = 64'd1 << 23;
        e = e + 1;
      end
    end
    return {neg, 8'(e), 23'(q - (64'd1 << 23))};
  endfunction

  // Edges from acceptance until out_valid: 1 for zero, leading zeros + 2 otherwise.
  function automatic int refLatency(input logic [31:0] value, input int width,
                                    input bit signedIn);
    longint unsigned mag;
    mag = refMagnitude(value, width, signedIn);
    if (mag == 0) return 1;
    return (width - 1 - refTopBit(mag)) + 2;
  endfunction

  // Hand one value to a DUT and wait (bounded) for its result.
  task automatic applyStimulus(input int d, input logic [31:0] value,
                               output logic [31:0] result, output int edges);
    @(negedge clk);
    checkOutput($sformatf("dut%0d in_ready before accept", d), 32'(inReady[d]), 32'd1);
    if (d == 0) inA16 = value[15:0];
    else        inA32 = value;
    inValid[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValid[d] = 1'b0;
    edges = 1;
    while (!outValid[d] && edges < 200) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    checkOutput($sformatf("dut%0d out_valid raised", d), 32'(outValid[d]), 32'd1);
    result = outB[d];
  endtask

  // Consumer takes the result; the DUT must be back in IDLE one edge later.
  task automatic releaseOutput(input int d);
    outReady[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    outReady[d] = 1'b0;
    checkOutput($sformatf("dut%0d out_valid after take", d), 32'(outValid[d]), 32'd0);
    checkOutput($sformatf("dut%0d in_ready after take", d), 32'(inReady[d]), 32'd1);
  endtask

  task automatic runVector(input int d, input logic [31:0] value,
                           input logic [31:0] expB, input int expEdges);
    logic [31:0] result;
    int          edges;
    applyStimulus(d, value, result, edges);
    checkOutput($sformatf("dut%0d out_b for 0x%08h", d, value), result, expB);
    checkOutput($sformatf("dut%0d latency for 0x%08h", d, value), 32'(edges), 32'(expEdges));
    releaseOutput(d);
  endtask

  initial begin
    logic [31:0] value;
    logic [31:0] result;
    int          edges;
    int          width;
    bit          signedIn;
    bit          truncate;

    vectors[0] = '{0, 32'h0000_0001, 32'h3F80_0000, 17};
    vectors[1] = '{0, 32'h0000_0000, 32'h0000_0000, 1};
    vectors[2] = '{0, 32'h0000_FFFC, 32'hC080_0000, 15};
    vectors[3] = '{0, 32'h0000_8000, 32'hC700_0000, 2};
    vectors[4] = '{1, 32'h0100_0001, 32'h4B80_0000, 9};
    vectors[5] = '{1, 32'h0100_0003, 32'h4B80_0002, 9};
    vectors[6] = '{1, 32'hFFFF_FFFF, 32'h4F80_0000, 2};
    vectors[7] = '{2, 32'h0100_0001, 32'h4B80_0000, 9};
    vectors[8] = '{2, 32'h0100_0003, 32'h4B80_0001, 9};
    vectors[9] = '{2, 32'hFFFF_FFFF, 32'h4F7F_FFFF, 2};

    rst_n    = 1'b0;
    inValid  = 3'b000;
    outReady = 3'b000;
    inA16    = 16'h0;
    inA32    = 32'h0;

    // Reset values.
    #12;
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("dut%0d reset in_ready", d), 32'(inReady[d]), 32'd1);
      checkOutput($sformatf("dut%0d reset out_valid", d), 32'(outValid[d]), 32'd0);
      checkOutput($sformatf("dut%0d reset out_b", d), outB[d], 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      runVector(vectors[i].dut, vectors[i].value, vectors[i].expB, vectors[i].expEdges);
    end

    // Random values against the arithmetic model, biased toward small ones.
    for (int d = 0; d < 3; d++) begin
      width    = (d == 0) ? 16 : 32;
      signedIn = (d == 0);
      truncate = (d == 2);
      for (int n = 0; n < 30; n++) begin
        value = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 9) == 0) value = 32'h0;
        if (d == 0) value = {16'h0, value[15:0]};
        runVector(d, value, refConvert(value, width, signedIn, truncate),
                  refLatency(value, width, signedIn));
      end
    end

    // Backpressure: result held, new input ignored while DONE.
    applyStimulus(0, 32'h0000_0005, result, edges);
    checkOutput("backpressure out_b", result, 32'h40A0_0000);
    checkOutput("backpressure latency", 32'(edges), 32'd15);
    inA16      = 16'h0007;
    inValid[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("backpressure hold out_b", outB[0], 32'h40A0_0000);
      checkOutput("backpressure hold out_valid", 32'(outValid[0]), 32'd1);
      checkOutput("backpressure hold in_ready", 32'(inReady[0]), 32'd0);
    end
    inValid[0] = 1'b0;
    releaseOutput(0);
    checkOutput("out_b kept after take", outB[0], 32'h40A0_0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("ignored input stays idle", 32'(inReady[0]), 32'd1);

    // Reset in the middle of normalisation.
    @(negedge clk);
    inA16      = 16'h0001;
    inValid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    checkOutput("mid-norm busy before reset", 32'(inReady[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("reset mid-norm in_ready", 32'(inReady[0]), 32'd1);
    checkOutput("reset mid-norm out_valid", 32'(outValid[0]), 32'd0);
    checkOutput("reset mid-norm out_b", outB[0], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    runVector(0, 32'h0000_0003, 32'h4040_0000, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
